// File: rtl/memory_access_if.sv
// Bus between the execute stage and the memory-access stage of the pipeline.
// The master drives the EX/MEM request side; the slave returns the MEM/WB results.
interface memory_access_if;
  logic [31:0] ALUout;
  logic [31:0] ALUoutBK;
  logic [4:0]  XM_RD;
  logic [2:0]  XM_MemCtr;
  logic [31:0] XM_RegtoMem;
  logic [2:0]  XM_BranchCtr;
  logic [31:0] XM_BranchAddr;

  logic [31:0] MW_Result;
  logic [4:0]  MW_RD;
  logic        MW_RegWrite;
  logic        MEM_stall;
  logic        MW_BranchTaken;
  logic [31:0] MW_BranchAddr;
  logic        MW_Misalign;

  modport master (
    output ALUout, ALUoutBK, XM_RD, XM_MemCtr, XM_RegtoMem, XM_BranchCtr, XM_BranchAddr,
    input  MW_Result, MW_RD, MW_RegWrite, MEM_stall, MW_BranchTaken, MW_BranchAddr, MW_Misalign
  );

  modport slave (
    input  ALUout, ALUoutBK, XM_RD, XM_MemCtr, XM_RegtoMem, XM_BranchCtr, XM_BranchAddr,
    output MW_Result, MW_RD, MW_RegWrite, MEM_stall, MW_BranchTaken, MW_BranchAddr, MW_Misalign
  );
endinterface

// File: rtl/memory_access.sv
// Memory-access pipeline stage: word data memory, HI/LO divide registers, branch redirect.
// Loads take two cycles (stall for one); every other op completes in one registered cycle.
module memory_access #(
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input logic              clk,
  input logic              rst,
  memory_access_if.slave   bus_io
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  localparam logic [2:0] OpAlu  = 3'd0;
  localparam logic [2:0] OpLw   = 3'd1;
  localparam logic [2:0] OpSw   = 3'd2;
  localparam logic [2:0] OpDiv  = 3'd3;
  localparam logic [2:0] OpMfhi = 3'd4;
  localparam logic [2:0] OpMflo = 3'd5;

  typedef enum logic [0:0] {StIdle, StLoadWait} state_e;

  state_e                state_q;
  logic [31:0]           result_q;
  logic [4:0]            rd_q;
  logic                  regwrite_q;
  logic                  stall_q;
  logic                  branch_q;
  logic [31:0]           baddr_q;
  logic                  misalign_q;
  logic [31:0]           hi_q;
  logic [31:0]           lo_q;
  logic [DEPTH_LOG2-1:0] ld_idx_q;
  logic [4:0]            ld_rd_q;

  logic [31:0]           mem_q [Depth];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  aligned;
  logic                  mem_we;

  // Upper address bits are dropped so accesses wrap within the array.
  assign idx     = bus_io.ALUout[DEPTH_LOG2+1:2];
  assign aligned = (bus_io.ALUout[1:0] == 2'b00);
  // Reset wins over a coincident store; stores presented during a stall are dropped.
  assign mem_we  = !rst && (state_q == StIdle) && (bus_io.XM_MemCtr == OpSw) && aligned;

  // Memory has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= bus_io.XM_RegtoMem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      result_q   <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      stall_q    <= 1'b0;
      branch_q   <= 1'b0;
      baddr_q    <= '0;
      misalign_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      ld_idx_q   <= '0;
      ld_rd_q    <= '0;
    end else begin
      branch_q   <= 1'b0;
      misalign_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          regwrite_q <= 1'b0;
          stall_q    <= 1'b0;
          if (bus_io.XM_BranchCtr != 3'd0) begin
            branch_q <= 1'b1;
            baddr_q  <= bus_io.XM_BranchAddr;
          end
          case (bus_io.XM_MemCtr)
            OpAlu: begin
              result_q   <= bus_io.ALUout;
              rd_q       <= bus_io.XM_RD;
              regwrite_q <= 1'b1;
            end
            OpLw: begin
              if (aligned) begin
                ld_idx_q <= idx;
                ld_rd_q  <= bus_io.XM_RD;
                stall_q  <= 1'b1;
                state_q  <= StLoadWait;
              end else begin
                misalign_q <= 1'b1;
              end
            end
            OpSw: begin
              if (!aligned) begin
                misalign_q <= 1'b1;
              end
            end
            OpDiv: begin
              hi_q <= bus_io.ALUout;
              lo_q <= bus_io.ALUoutBK;
            end
            OpMfhi: begin
              result_q   <= hi_q;
              rd_q       <= bus_io.XM_RD;
              regwrite_q <= 1'b1;
            end
            OpMflo: begin
              result_q   <= lo_q;
              rd_q       <= bus_io.XM_RD;
              regwrite_q <= 1'b1;
            end
            default: ;
          endcase
        end
        StLoadWait: begin
          // Inputs this cycle are ignored; upstream re-presents them once stall drops.
          result_q   <= mem_q[ld_idx_q];
          rd_q       <= ld_rd_q;
          regwrite_q <= 1'b1;
          stall_q    <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.MW_Result      = result_q;
  assign bus_io.MW_RD          = rd_q;
  assign bus_io.MW_RegWrite    = regwrite_q;
  assign bus_io.MEM_stall      = stall_q;
  assign bus_io.MW_BranchTaken = branch_q;
  assign bus_io.MW_BranchAddr  = baddr_q;
  assign bus_io.MW_Misalign    = misalign_q;

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: stimulus pushes expected writeback/branch/misalign
// events, a negedge monitor pops and compares each event the stage produces.
module tb_memory_access;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_access_if bus ();

  memory_access #(.DEPTH_LOG2(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct {
    logic        rw;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        br;
    logic [31:0] baddr;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t mk(logic rw, logic [31:0] res, logic [4:0] rd,
                              logic br, logic [31:0] baddr, logic mis);
    exp_t e;
    e.rw = rw; e.res = res; e.rd = rd; e.br = br; e.baddr = baddr; e.mis = mis;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: any output event must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.MW_RegWrite === 1'b1 || bus.MW_BranchTaken === 1'b1 || bus.MW_Misalign === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got rw=%b res=%h rd=%0d br=%b baddr=%h mis=%b, required none",
                 bus.MW_RegWrite, bus.MW_Result, bus.MW_RD, bus.MW_BranchTaken,
                 bus.MW_BranchAddr, bus.MW_Misalign);
      end else begin
        mon_e = sb.pop_front();
        if (!((bus.MW_RegWrite === mon_e.rw) && (bus.MW_BranchTaken === mon_e.br) &&
              (bus.MW_Misalign === mon_e.mis) &&
              (!mon_e.rw || (bus.MW_Result === mon_e.res && bus.MW_RD === mon_e.rd)) &&
              (!mon_e.br || bus.MW_BranchAddr === mon_e.baddr))) begin
          n_bad++;
          $display("FAIL event: got rw=%b res=%h rd=%0d br=%b baddr=%h mis=%b, required rw=%b res=%h rd=%0d br=%b baddr=%h mis=%b",
                   bus.MW_RegWrite, bus.MW_Result, bus.MW_RD, bus.MW_BranchTaken,
                   bus.MW_BranchAddr, bus.MW_Misalign, mon_e.rw, mon_e.res, mon_e.rd,
                   mon_e.br, mon_e.baddr, mon_e.mis);
        end
      end
    end
  end

  task automatic set_in(input logic [2:0] op, input logic [31:0] alu, input logic [31:0] bk,
                        input logic [31:0] st, input logic [4:0] rd, input logic [2:0] bc,
                        input logic [31:0] ba);
    bus.XM_MemCtr     = op;
    bus.ALUout        = alu;
    bus.ALUoutBK      = bk;
    bus.XM_RegtoMem   = st;
    bus.XM_RD         = rd;
    bus.XM_BranchCtr  = bc;
    bus.XM_BranchAddr = ba;
  endtask

  task automatic nop_in();
    set_in(3'd6, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op and hold it until a cycle without stall accepts it.
  task automatic issue(input logic [2:0] op, input logic [31:0] alu, input logic [31:0] bk,
                       input logic [31:0] st, input logic [4:0] rd, input logic [2:0] bc,
                       input logic [31:0] ba);
    bit done = 1'b0;
    logic s;
    set_in(op, alu, bk, st, rd, bc, ba);
    for (int i = 0; i < 4 && !done; i++) begin
      s = bus.MEM_stall;
      step();
      if (s === 1'b0) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: got stall held, required acceptance within 4 cycles");
    end
    nop_in();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_result"}, bus.MW_Result, 32'h0);
    chk({tag, "_rd"}, {27'h0, bus.MW_RD}, 32'h0);
    chk({tag, "_regwrite"}, {31'h0, bus.MW_RegWrite}, 32'h0);
    chk({tag, "_stall"}, {31'h0, bus.MEM_stall}, 32'h0);
    chk({tag, "_branch"}, {31'h0, bus.MW_BranchTaken}, 32'h0);
    chk({tag, "_baddr"}, bus.MW_BranchAddr, 32'h0);
    chk({tag, "_misalign"}, {31'h0, bus.MW_Misalign}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    nop_in();
    step();
    step();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // ALU writeback
    sb.push_back(mk(1'b1, 32'h15, 5'd3, 1'b0, 32'h0, 1'b0));
    issue(3'd0, 32'h15, 32'h0, 32'h0, 5'd3, 3'd0, 32'h0);

    // SW then immediate LW, with one stall cycle
    issue(3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 5'd0, 3'd0, 32'h0);
    sb.push_back(mk(1'b1, 32'hDEADBEEF, 5'd8, 1'b0, 32'h0, 1'b0));
    set_in(3'd1, 32'h10, 32'h0, 32'h0, 5'd8, 3'd0, 32'h0);
    step();
    chk("lw_stall", {31'h0, bus.MEM_stall}, 32'h1);
    nop_in();
    step();
    chk("lw_stall_clear", {31'h0, bus.MEM_stall}, 32'h0);

    // DIV followed directly by MFHI / MFLO
    issue(3'd3, 32'h2, 32'h7, 32'h0, 5'd0, 3'd0, 32'h0);
    sb.push_back(mk(1'b1, 32'h2, 5'd4, 1'b0, 32'h0, 1'b0));
    issue(3'd4, 32'h0, 32'h0, 32'h0, 5'd4, 3'd0, 32'h0);
    sb.push_back(mk(1'b1, 32'h7, 5'd5, 1'b0, 32'h0, 1'b0));
    issue(3'd5, 32'h0, 32'h0, 32'h0, 5'd5, 3'd0, 32'h0);

    // Misaligned LW and SW
    sb.push_back(mk(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1));
    issue(3'd1, 32'h11, 32'h0, 32'h0, 5'd9, 3'd0, 32'h0);
    chk("misalign_no_stall", {31'h0, bus.MEM_stall}, 32'h0);
    sb.push_back(mk(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1));
    issue(3'd2, 32'h11, 32'h0, 32'h12345678, 5'd0, 3'd0, 32'h0);

    // Branch alone, then branch alongside an ALU writeback
    sb.push_back(mk(1'b0, 32'h0, 5'd0, 1'b1, 32'h40, 1'b0));
    issue(3'd6, 32'h0, 32'h0, 32'h0, 5'd0, 3'd1, 32'h40);
    sb.push_back(mk(1'b1, 32'hAB, 5'd7, 1'b1, 32'h80, 1'b0));
    issue(3'd0, 32'hAB, 32'h0, 32'h0, 5'd7, 3'd3, 32'h80);

    // Branch and SW presented during a stall are both ignored
    issue(3'd2, 32'h20, 32'h0, 32'h11111111, 5'd0, 3'd0, 32'h0);
    sb.push_back(mk(1'b1, 32'h11111111, 5'd10, 1'b0, 32'h0, 1'b0));
    set_in(3'd1, 32'h20, 32'h0, 32'h0, 5'd10, 3'd0, 32'h0);
    step();
    chk("stall_for_ignore", {31'h0, bus.MEM_stall}, 32'h1);
    set_in(3'd2, 32'h20, 32'h0, 32'h22222222, 5'd0, 3'd1, 32'h40);
    step();
    nop_in();
    sb.push_back(mk(1'b1, 32'h11111111, 5'd11, 1'b0, 32'h0, 1'b0));
    issue(3'd1, 32'h20, 32'h0, 32'h0, 5'd11, 3'd0, 32'h0);
    // Misaligned SW to 0x11 must not have touched word 0x10
    sb.push_back(mk(1'b1, 32'hDEADBEEF, 5'd12, 1'b0, 32'h0, 1'b0));
    issue(3'd1, 32'h10, 32'h0, 32'h0, 5'd12, 3'd0, 32'h0);

    // Address wrap: 0x210 aliases word 0x10 in a 64-word memory
    issue(3'd2, 32'h210, 32'h0, 32'hCAFEF00D, 5'd0, 3'd0, 32'h0);
    sb.push_back(mk(1'b1, 32'hCAFEF00D, 5'd13, 1'b0, 32'h0, 1'b0));
    issue(3'd1, 32'h10, 32'h0, 32'h0, 5'd13, 3'd0, 32'h0);

    // Reset beats a simultaneous SW; memory survives reset; HI cleared
    issue(3'd2, 32'h30, 32'h0, 32'hAAAA0001, 5'd0, 3'd0, 32'h0);
    rst = 1'b1;
    set_in(3'd2, 32'h30, 32'h0, 32'hBBBB0002, 5'd0, 3'd0, 32'h0);
    step();
    rst = 1'b0;
    nop_in();
    sb.push_back(mk(1'b1, 32'hAAAA0001, 5'd14, 1'b0, 32'h0, 1'b0));
    issue(3'd1, 32'h30, 32'h0, 32'h0, 5'd14, 3'd0, 32'h0);
    sb.push_back(mk(1'b1, 32'h0, 5'd15, 1'b0, 32'h0, 1'b0));
    issue(3'd4, 32'h0, 32'h0, 32'h0, 5'd15, 3'd0, 32'h0);

    // Reset during LOAD_WAIT discards the load
    sb.push_back(mk(1'b1, 32'h77, 5'd2, 1'b1, 32'h90, 1'b0));
    issue(3'd0, 32'h77, 32'h0, 32'h0, 5'd2, 3'd1, 32'h90);
    set_in(3'd1, 32'h10, 32'h0, 32'h0, 5'd16, 3'd0, 32'h0);
    step();
    chk("lw_wait_stall", {31'h0, bus.MEM_stall}, 32'h1);
    rst = 1'b1;
    nop_in();
    step();
    rst = 1'b0;
    chk_reset_outputs("rst_in_wait");
    step();
    step();
    step();

    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
